// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: PC/IF-ID/ID-EX enables, bubbles, flushes for load-use, branch, mul/div.
// Latency: Mealy outputs, zero-cycle from inputs; optional HAZ_PERF_CNT_EN adds stall/flush counters.
// Backpressure: stalls front end on load-use (1 cycle) and holds it in MC_WAIT until mc_done/timeout.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64,
  parameter int REG_AW       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_mc_start,
  input  logic              mc_done,
  input  logic              branch_taken,
`ifdef HAZ_PERF_CNT_EN
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_cycles,
`endif
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_write,
  output logic              idex_bubble,
  output logic              mc_timeout,
  output logic              busy
);

  typedef enum logic [1:0] {RUN, FLUSH, MC_WAIT} state_t;

  state_t     state;
  logic [2:0] flush_cnt;
  logic [7:0] mc_cnt;
  logic       lu;
  logic       mc_to;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu = id_valid & ex_memread & (ex_rt != '0) &
              ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  assign mc_to = (state == MC_WAIT) & ~mc_done & (mc_cnt == 8'(MC_TIMEOUT - 1));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    mc_timeout  = 1'b0;
    busy        = 1'b0;
    // Reset forces run values regardless of what the inputs are doing
    if (rst_n) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (ex_mc_start) begin
            idex_bubble = 1'b0;
          end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          busy        = 1'b1;
        end
        MC_WAIT: begin
          busy = 1'b1;
          if (!mc_done) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            mc_timeout = mc_to;
          end
        end
        default: busy = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= '0;
      mc_cnt    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
              state     <= FLUSH;
              flush_cnt <= 3'(FLUSH_CYCLES - 1);
            end
          end else if (ex_mc_start) begin
            state  <= MC_WAIT;
            mc_cnt <= '0;
          end
        end
        FLUSH: begin
          if (flush_cnt <= 3'd1) begin
            state     <= RUN;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        MC_WAIT: begin
          if (mc_done || mc_to) begin
            state  <= RUN;
            mc_cnt <= '0;
          end else if (mc_cnt != 8'hFF) begin
            mc_cnt <= mc_cnt + 8'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!pc_write && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (ifid_flush && flush_cycles != 16'hFFFF) flush_cycles <= flush_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expected control vectors queued at drive time, checked at negedge.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rt, ex_memread, ex_mc_start, mc_done, branch_taken;
  logic [2:0] id_rs, id_rt, ex_rt;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mc_timeout, busy;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_cycles;
`endif

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MC_TIMEOUT(8), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_mc_start(ex_mc_start),
    .mc_done(mc_done), .branch_taken(branch_taken),
`ifdef HAZ_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .mc_timeout(mc_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mc_timeout, busy}
  localparam logic [6:0] V_RUN   = 7'b1101000;
  localparam logic [6:0] V_LU    = 7'b0001100;
  localparam logic [6:0] V_BR    = 7'b1111100;
  localparam logic [6:0] V_FLUSH = 7'b1111101;
  localparam logic [6:0] V_HOLD  = 7'b0000001;
  localparam logic [6:0] V_DONE  = 7'b1101001;
  localparam logic [6:0] V_TO    = 7'b0000011;

  typedef struct {
    logic [6:0] exp;
    string      tag;
  } sb_t;

  sb_t sb_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  function automatic logic [6:0] obs();
    return {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mc_timeout, busy};
  endfunction

  task automatic drive(input logic bt, input logic mem, input logic [2:0] ert,
                       input logic [2:0] rs, input logic [2:0] rt, input logic urt,
                       input logic vld, input logic mcs, input logic done);
    branch_taken = bt; ex_memread = mem; ex_rt = ert; id_rs = rs; id_rt = rt;
    id_uses_rt = urt; id_valid = vld; ex_mc_start = mcs; mc_done = done;
  endtask

  task automatic idle();
    drive(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0);
  endtask

  task automatic compare_head();
    sb_t e;
    logic [6:0] o;
    e = sb_q.pop_front();
    o = obs();
    vectors++;
    assert (o === e.exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", e.tag, o, e.exp);
    end
  endtask

  // Check current outputs without a clock edge
  task automatic check_now(input logic [6:0] exp, input string tag);
    sb_t e;
    e.exp = exp; e.tag = tag;
    sb_q.push_back(e);
    #1;
    compare_head();
  endtask

  // Expectation queued with the stimulus, compared at the following negedge, then advance a cycle
  task automatic step(input logic [6:0] exp, input string tag);
    sb_t e;
    e.exp = exp; e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    check_now(V_RUN, "reset_idle");
    drive(1, 1, 3'd5, 3'd5, 3'd0, 0, 1, 1, 0);
    check_now(V_RUN, "reset_inputs_active");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    step(V_RUN, "idle");
    // load-use on rs, single-cycle stall
    drive(0, 1, 3'd5, 3'd5, 3'd0, 0, 1, 0, 0); step(V_LU, "lu_rs");
    drive(0, 0, 3'd5, 3'd5, 3'd0, 0, 1, 0, 0); step(V_RUN, "lu_cleared");
    drive(0, 1, 3'd3, 3'd1, 3'd3, 1, 1, 0, 0); step(V_LU, "lu_rt");
    drive(0, 1, 3'd3, 3'd1, 3'd3, 0, 1, 0, 0); step(V_RUN, "rt_unused");
    drive(0, 1, 3'd5, 3'd5, 3'd0, 0, 0, 0, 0); step(V_RUN, "id_invalid");
    drive(0, 1, 3'd0, 3'd0, 3'd0, 1, 1, 0, 0); step(V_RUN, "load_r0");

    // taken branch: two flush cycles, branch in FLUSH ignored
    drive(1, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0); step(V_BR, "br_run");
    step(V_FLUSH, "br_flush2");
    idle(); step(V_RUN, "br_back_run");

    // branch beats load-use, then beats mc start
    drive(1, 1, 3'd4, 3'd4, 3'd0, 0, 1, 0, 0); step(V_BR, "br_lu_run");
    step(V_FLUSH, "br_lu_flush");
    idle(); step(V_RUN, "br_lu_back");
    drive(1, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0); step(V_BR, "br_mc_run");
    idle(); step(V_FLUSH, "br_mc_flush");
    step(V_RUN, "br_mc_no_wait");

    // multi-cycle op: 5 held cycles, release on mc_done
    drive(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0); step(V_RUN, "mc_start");
    idle(); step(V_HOLD, "mc_hold1");
    drive(1, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0); step(V_HOLD, "mc_hold_br");
    drive(0, 1, 3'd2, 3'd2, 3'd0, 0, 1, 0, 0); step(V_HOLD, "mc_hold_lu");
    idle(); step(V_HOLD, "mc_hold4");
    step(V_HOLD, "mc_hold5");
    drive(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1); step(V_DONE, "mc_done");
    idle(); step(V_RUN, "mc_back_run");

    // timeout on 8th wait cycle
    drive(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0); step(V_RUN, "to_start");
    idle();
    for (int i = 1; i < 8; i++) step(V_HOLD, $sformatf("to_hold%0d", i));
    step(V_TO, "to_pulse");
    step(V_RUN, "to_back_run");

    // mc_done coincident with timeout: no pulse
    drive(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0); step(V_RUN, "tie_start");
    idle();
    for (int i = 1; i < 8; i++) step(V_HOLD, $sformatf("tie_hold%0d", i));
    drive(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1); step(V_DONE, "tie_done_wins");
    idle(); step(V_RUN, "tie_back_run");

    // async reset mid-FLUSH
    drive(1, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0); step(V_BR, "rf_br");
    idle();
    check_now(V_FLUSH, "rf_in_flush");
    rst_n = 1'b0;
    check_now(V_RUN, "rf_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(V_RUN, "rf_no_residual");

    // async reset mid-MC_WAIT
    drive(0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 1, 0); step(V_RUN, "rm_start");
    idle(); step(V_HOLD, "rm_hold");
    check_now(V_HOLD, "rm_in_wait");
    rst_n = 1'b0;
    check_now(V_RUN, "rm_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(V_RUN, "rm_no_residual");
    step(V_RUN, "rm_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage 19-bit CPU. It drives the write-enable, bubble and flush controls of the PC, IF/ID and ID/EX pipeline registers. It resolves three conditions: load-use hazards, taken branches resolved in EX, and multi-cycle EX operations (mul/div) that hold the pipeline until done. The datapath registers themselves are unchanged; they only consume these controls.

Parameters:
FLUSH_CYCLES, 2, number of bubble cycles inserted into ID/EX after a taken branch (1..7)
MC_TIMEOUT, 64, max cycles spent in MC_WAIT before forced release (2..255)
REG_AW, 3, register-index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  instruction in ID is valid
id_rs  in  REG_AW  ID source register 1
id_rt  in  REG_AW  ID source register 2
id_uses_rt  in  1  ID instruction reads rt (R-type/store)
ex_memread  in  1  instruction in EX is a load
ex_rt  in  REG_AW  load destination register in EX
ex_mc_start  in  1  multi-cycle op entered EX this cycle
mc_done  in  1  multi-cycle unit result ready
branch_taken  in  1  branch resolved taken in EX
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_write  out  1  ID/EX load enable
idex_bubble  out  1  load zeros into ID/EX control fields (regwrite, memread, memwrite, etc.)
mc_timeout  out  1  one-cycle pulse on forced MC_WAIT exit
busy  out  1  FSM not in RUN

Behaviour:
- Outputs are Mealy: combinational from state and inputs. State, flush_cnt (3b) and mc_cnt (8b) are registered.
- Reset (async, rst_n=0): state=RUN, counters=0. Outputs immediately: pc_write=1, ifid_write=1, idex_write=1, ifid_flush=0, idex_bubble=0, mc_timeout=0, busy=0. Reset mid-stall or mid-flush abandons the operation with no residual bubble.
- Load-use hazard: lu = id_valid & ex_memread & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)). Register 0 is hardwired zero and never creates a hazard.
- State RUN, inputs evaluated in priority order:
  - branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1. If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - ex_mc_start: go to MC_WAIT with mc_cnt=0. Outputs stay at run values this cycle.
  - lu: pc_write=0, ifid_write=0, idex_bubble=1. Stay in RUN. This is a single-cycle stall; the bubble clears the hazard on the next cycle.
  - otherwise: all enables=1, no bubble, no flush.
- State FLUSH:
  - Outputs: idex_bubble=1, ifid_flush=1, pc_write=1, busy=1.
  - flush_cnt decrements each cycle; at flush_cnt==1, go to RUN.
  - A branch_taken seen in FLUSH is ignored, since EX holds a bubble.
- State MC_WAIT:
  - Outputs: pc_write=0, ifid_write=0, idex_write=0, idex_bubble=0, busy=1. The whole front end is held.
  - mc_cnt increments each cycle.
  - mc_done=1: go to RUN. Enables are restored the same cycle.
  - mc_cnt==MC_TIMEOUT-1 without mc_done: mc_timeout=1 for that cycle, then go to RUN.
  - If mc_done and the timeout coincide, mc_done wins and no pulse is raised.
  - branch_taken and lu are ignored in MC_WAIT. The held EX instruction is re-evaluated on return to RUN.
- Simultaneous branch_taken and lu in RUN: the flush wins and there is no stall, because the dependent instruction is squashed.
- Simultaneous branch_taken and ex_mc_start in RUN: the flush wins and the mc op is treated as squashed by the datapath.
- Counter widths saturate at parameter limits; there is no wrap-around in legal configurations.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[15:0] and flush_cycles[15:0], both reset to 0 on rst_n.
  - stall_cycles increments on every cycle with pc_write=0.
  - flush_cycles increments on every cycle with ifid_flush=1.
  - Both saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist, and the other behaviour is identical.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_valid=1 for one cycle, then ex_memread=0 -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle, then all enables=1.
- Load to r0: ex_memread=1, ex_rt=0, id_rs=0 -> no stall; pc_write stays 1.
- Branch: branch_taken=1 for 1 cycle with FLUSH_CYCLES=2 -> ifid_flush=1 and idex_bubble=1 for 2 consecutive cycles, busy=1 on the 2nd cycle, then RUN.
- Multi-cycle: ex_mc_start pulse, mc_done asserted 5 cycles later -> idex_write=0 and pc_write=0 for 5 cycles, busy=1, enables return to 1 on the mc_done cycle.
- Timeout: MC_TIMEOUT=8, ex_mc_start with no mc_done -> mc_timeout pulses once on the 8th MC_WAIT cycle, then RUN.
- Async reset: assert rst_n=0 mid-FLUSH and mid-MC_WAIT -> outputs go to reset values immediately without a clock edge; after release, busy=0 and no bubble.
